// File: rtl/soc_system_sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the system ID slave.
interface soc_system_sysid_checker_if #(
    parameter int DATA_W = 32
);
    logic              avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/soc_system_sysid_checker.sv
// Reads the two-word system ID slave after a start pulse and flags whether the
// running FPGA image carries the expected ID and build timestamp.
module soc_system_sysid_checker #(
    parameter int                DATA_W         = 32,
    parameter logic [DATA_W-1:0] EXPECTED_ID    = 32'hACD51302,
    parameter logic [DATA_W-1:0] EXPECTED_TS    = 32'h560CC9C4,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                id_ok,
    output logic                ts_ok,
    output logic                timeout,
    output logic [DATA_W-1:0]   id_value,
    output logic [DATA_W-1:0]   ts_value,
    soc_system_sysid_checker_if.master avm
);

    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W  = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, FINISH
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              addr_q;
    logic              tmo_hit;
    logic              clear_all, load_cnt, cap_id, cap_ts, expire;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A transaction expires on its last budgeted cycle unless its data arrives in that same cycle.
    always_comb begin
        state_nxt = state;
        clear_all = 1'b0;
        load_cnt  = 1'b0;
        cap_id    = 1'b0;
        cap_ts    = 1'b0;
        expire    = 1'b0;
        tmo_hit   = TMO_EN && (tmo_cnt == CNT_W'(1));
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RD_ID;
                    clear_all = 1'b1;
                    load_cnt  = 1'b1;
                end
            end
            RD_ID: begin
                if (tmo_hit) begin
                    state_nxt = FINISH;
                    expire    = 1'b1;
                end else if (!avm.avm_waitrequest) begin
                    state_nxt = WAIT_ID;
                end
            end
            WAIT_ID: begin
                if (avm.avm_readdatavalid) begin
                    state_nxt = RD_TS;
                    cap_id    = 1'b1;
                    load_cnt  = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = FINISH;
                    expire    = 1'b1;
                end
            end
            RD_TS: begin
                if (tmo_hit) begin
                    state_nxt = FINISH;
                    expire    = 1'b1;
                end else if (!avm.avm_waitrequest) begin
                    state_nxt = WAIT_TS;
                end
            end
            WAIT_TS: begin
                if (avm.avm_readdatavalid) begin
                    state_nxt = FINISH;
                    cap_ts    = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = FINISH;
                    expire    = 1'b1;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt  <= '0;
            addr_q   <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (load_cnt)
                tmo_cnt <= CNT_W'(TIMEOUT_CYCLES);
            else if (busy && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;

            if (clear_all) begin
                addr_q   <= 1'b0;
                id_value <= '0;
                ts_value <= '0;
                id_ok    <= 1'b0;
                ts_ok    <= 1'b0;
                pass     <= 1'b0;
                timeout  <= 1'b0;
            end
            // Address flips to the timestamp word only once the ID response is in.
            if (cap_id) begin
                id_value <= avm.avm_readdata;
                id_ok    <= (avm.avm_readdata == EXPECTED_ID);
                addr_q   <= 1'b1;
            end
            if (cap_ts) begin
                ts_value <= avm.avm_readdata;
                ts_ok    <= (avm.avm_readdata == EXPECTED_TS);
                pass     <= id_ok && (avm.avm_readdata == EXPECTED_TS);
            end
            if (expire)
                timeout <= 1'b1;
        end
    end

    assign busy            = (state == RD_ID) || (state == WAIT_ID) ||
                             (state == RD_TS) || (state == WAIT_TS);
    assign done            = (state == FINISH);
    assign avm.avm_read    = (state == RD_ID) || (state == RD_TS);
    assign avm.avm_address = addr_q;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Scoreboard bench for soc_system_sysid_checker: a scripted Avalon slave feeds
// directed words, expectations are queued at start and checked on done.
module tb_soc_system_sysid_checker;

    localparam logic [31:0] ID_GOOD = 32'hACD51302;
    localparam logic [31:0] TS_GOOD = 32'h560CC9C4;

    logic        clock;
    logic        reset;
    logic        start;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    soc_system_sysid_checker_if #(.DATA_W(32)) bus ();

    soc_system_sysid_checker #(
        .DATA_W         (32),
        .EXPECTED_ID    (ID_GOOD),
        .EXPECTED_TS    (TS_GOOD),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .id_ok    (id_ok),
        .ts_ok    (ts_ok),
        .timeout  (timeout),
        .id_value (id_value),
        .ts_value (ts_value),
        .avm      (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          start_cyc;
        int          lat;
        logic [31:0] idv;
        logic [31:0] tsv;
        logic        iok;
        logic        tok;
        logic        ps;
        logic        tmo;
    } exp_t;

    exp_t q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic exp_t mk(input int lat, input logic [31:0] idv, input logic [31:0] tsv,
                                input logic iok, input logic tok, input logic ps, input logic tmo);
        exp_t e;
        e.start_cyc = 0;
        e.lat = lat; e.idv = idv; e.tsv = tsv;
        e.iok = iok; e.tok = tok; e.ps = ps; e.tmo = tmo;
        return e;
    endfunction

    // Scripted slave: stall wr_cycles per command, answer latency cycles after acceptance.
    int          wr_cycles = 0;
    int          latency   = 1;
    logic [31:0] word0     = ID_GOOD;
    logic [31:0] word1     = TS_GOOD;
    bit          drop0     = 0;
    bit          drop1     = 0;
    bit          stray_req = 0;
    logic [31:0] stray_data = '0;
    bit          saw_addr1 = 0;
    int          stall_cnt = 0;
    int          pend      = 0;
    logic        pend_addr = 1'b0;

    initial begin
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        forever begin
            @(negedge clock);
            bus.avm_readdatavalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && !(pend_addr ? drop1 : drop0)) begin
                    bus.avm_readdatavalid = 1'b1;
                    bus.avm_readdata      = pend_addr ? word1 : word0;
                end
            end
            if (stray_req) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = stray_data;
                stray_req             = 0;
            end
            if (bus.avm_read) begin
                if (bus.avm_address) saw_addr1 = 1;
                if (stall_cnt < wr_cycles) begin
                    bus.avm_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    bus.avm_waitrequest = 1'b0;
                    stall_cnt = 0;
                    pend      = latency;
                    pend_addr = bus.avm_address;
                end
            end else begin
                bus.avm_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Command must hold still across a stalled edge.
    logic stalled_prev = 1'b0;
    logic addr_prev    = 1'b0;
    always @(posedge clock) begin
        stalled_prev <= bus.avm_read && bus.avm_waitrequest && !reset;
        addr_prev    <= bus.avm_address;
    end

    initial forever begin
        @(negedge clock);
        if (stalled_prev) begin
            chk("stall_read_held", bus.avm_read, 1'b1);
            chk("stall_addr_held", bus.avm_address, addr_prev);
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clock);
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("done_latency", cyc - e.start_cyc + 1, e.lat);
                chk("id_value",     id_value, e.idv);
                chk("ts_value",     ts_value, e.tsv);
                chk("id_ok",        id_ok,    e.iok);
                chk("ts_ok",        ts_ok,    e.tok);
                chk("pass",         pass,     e.ps);
                chk("timeout",      timeout,  e.tmo);
                chk("busy_at_done", busy,     1'b0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic slave_cfg(input logic [31:0] w0, input logic [31:0] w1, input int wr,
                             input int lat, input bit d0, input bit d1);
        word0 = w0; word1 = w1; wr_cycles = wr; latency = lat; drop0 = d0; drop1 = d1;
    endtask

    // Leaves the caller at the falling edge of cycle 1 with start low.
    task automatic start_check(input exp_t e);
        @(negedge clock);
        start = 1'b1;
        e.start_cyc = cyc + 1;
        q.push_back(e);
        @(negedge clock);
        start = 1'b0;
        chk("c1_busy",     busy,            1'b1);
        chk("c1_read",     bus.avm_read,    1'b1);
        chk("c1_addr",     bus.avm_address, 1'b0);
        chk("c1_pass_clr", pass,            1'b0);
        chk("c1_flags_clr", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
        chk("c1_vals_clr", id_value | ts_value, 32'd0);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL done_wait: got no done within %0d cycles, expected done", budget);
            q.delete();
        end
        @(negedge clock);
        chk("done_one_cycle", done, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {26'd0, busy, done, pass, id_ok, ts_ok, timeout}, 32'd0);
        chk({tag, "_bus"}, {30'd0, bus.avm_read, bus.avm_address}, 32'd0);
        chk({tag, "_id"},  id_value, 32'd0);
        chk({tag, "_ts"},  ts_value, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        tick(3);
        reset = 1'b0;
        check_all_zero("reset");

        // Matching slave, no stall, latency 1.
        slave_cfg(ID_GOOD, TS_GOOD, 0, 1, 0, 0);
        start_check(mk(5, ID_GOOD, TS_GOOD, 1, 1, 1, 0));
        wait_empty(60);

        // Timestamp off by one.
        slave_cfg(ID_GOOD, 32'h560CC9C5, 0, 1, 0, 0);
        start_check(mk(5, ID_GOOD, 32'h560CC9C5, 1, 0, 0, 0));
        wait_empty(60);

        // ID off by one.
        slave_cfg(32'hACD51303, TS_GOOD, 0, 1, 0, 0);
        start_check(mk(5, 32'hACD51303, TS_GOOD, 0, 1, 0, 0));
        wait_empty(60);

        // Three stall cycles per command, latency 2.
        slave_cfg(ID_GOOD, TS_GOOD, 3, 2, 0, 0);
        start_check(mk(13, ID_GOOD, TS_GOOD, 1, 1, 1, 0));
        wait_empty(60);

        // ID never answered: timeout, timestamp never requested.
        slave_cfg(ID_GOOD, TS_GOOD, 0, 1, 1, 0);
        saw_addr1 = 0;
        start_check(mk(9, 32'd0, 32'd0, 0, 0, 0, 1));
        wait_empty(60);
        chk("no_addr1_read", saw_addr1, 1'b0);

        // Timestamp never answered.
        slave_cfg(ID_GOOD, TS_GOOD, 0, 1, 0, 1);
        start_check(mk(11, ID_GOOD, 32'd0, 1, 0, 0, 1));
        wait_empty(60);

        // Response on the last budgeted cycle still counts.
        slave_cfg(ID_GOOD, TS_GOOD, 0, 7, 0, 0);
        start_check(mk(17, ID_GOOD, TS_GOOD, 1, 1, 1, 0));
        wait_empty(60);

        // One cycle too late: timeout, late data ignored.
        slave_cfg(ID_GOOD, TS_GOOD, 0, 8, 0, 0);
        start_check(mk(9, 32'd0, 32'd0, 0, 0, 0, 1));
        wait_empty(60);
        chk("late_data_ignored", id_value, 32'd0);

        // Start while busy and in FINISH, then a stray valid in IDLE.
        slave_cfg(ID_GOOD, TS_GOOD, 0, 1, 0, 0);
        start_check(mk(5, ID_GOOD, TS_GOOD, 1, 1, 1, 0));
        start = 1'b1;
        tick(2);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        chk("no_restart_c6", busy, 1'b0);
        @(posedge clock);
        #1;
        stray_data = 32'hDEADBEEF;
        stray_req  = 1;
        tick(2);
        chk("no_restart_c8", busy, 1'b0);
        chk("stray_id_kept", id_value, ID_GOOD);
        chk("stray_ts_kept", ts_value, TS_GOOD);
        chk("stray_pass_kept", pass, 1'b1);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL restart_done: got %0d pending checks, expected 0", q.size());
            q.delete();
        end

        // Reset while waiting for the timestamp; its late response must be ignored.
        slave_cfg(ID_GOOD, TS_GOOD, 0, 3, 0, 0);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        tick(5);
        chk("wait_ts_busy", busy, 1'b1);
        chk("wait_ts_addr", bus.avm_address, 1'b1);
        chk("wait_ts_read", bus.avm_read, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_all_zero("midreset");
        tick(2);
        check_all_zero("postreset");

        // Clean check after the aborted one.
        slave_cfg(ID_GOOD, TS_GOOD, 0, 1, 0, 0);
        start_check(mk(5, ID_GOOD, TS_GOOD, 1, 1, 1, 0));
        wait_empty(60);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc_system_sysid_checker.md
# soc_system_sysid_checker

Avalon-MM master that reads back the two-word system ID peripheral and checks the contents against build-time expected values. On a start pulse it issues a read of word 0 (system ID), then word 1 (timestamp), captures both, and reports per-word match, overall pass, and timeout status. It sits between the boot/health-check control logic and the interconnect port of the system ID slave, so that a mismatched FPGA image is flagged before software proceeds.

## Interface
- EXPECTED_ID, 32'hACD51302, expected word at address 0
- EXPECTED_TS, 32'h560CC9C4, expected word at address 1
- TIMEOUT_CYCLES, 1024, max cycles per read transaction (command plus response); 0 disables timeout
- clock  input  1  sole clock; all logic rising-edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to run a check
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when a check completes (pass, fail or timeout)
- pass  output  1  id_ok & ts_ok & !timeout; held until next accepted start
- id_ok  output  1  captured ID == EXPECTED_ID; held
- ts_ok  output  1  captured timestamp == EXPECTED_TS; held
- timeout  output  1  a transaction exceeded TIMEOUT_CYCLES; held
- id_value  output  32  captured word 0
- ts_value  output  32  captured word 1
- avm_address  output  1  word address (0 = ID, 1 = timestamp)
- avm_read  output  1  read command
- avm_waitrequest  input  1  slave stall; command held while high
- avm_readdata  input  32  read data
- avm_readdatavalid  input  1  read data qualifier

## Operation
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, FINISH.
- IDLE: start=1 -> RD_ID; clears id_ok, ts_ok, pass, timeout, id_value, ts_value; loads timeout counter.
- RD_ID: avm_read=1, avm_address=0. Held constant while avm_waitrequest=1. avm_waitrequest=0 -> WAIT_ID.
- WAIT_ID: avm_read=0. avm_readdatavalid=1 -> id_value<=avm_readdata, id_ok<=(avm_readdata==EXPECTED_ID), go RD_TS, reload counter.
- RD_TS / WAIT_TS: same as above with avm_address=1, capturing ts_value/ts_ok; on valid -> FINISH.
- FINISH: done=1 and pass registered for one cycle, then IDLE.
- Exactly one outstanding read; avm_readdatavalid outside WAIT_ID/WAIT_TS is ignored.
- Timeout: counter width $clog2(TIMEOUT_CYCLES+1); decrements each cycle in RD_*/WAIT_*; reaching 0 while not complete -> timeout=1, avm_read dropped, go FINISH (pass=0, ok flag of the unfinished word stays 0). Counter reloads at each new transaction.
- start while busy, or in FINISH, is ignored; start in IDLE after a previous check restarts and clears all held status.
- Comparisons are full 32-bit equality; no masking.

## Timing
- Reset: all outputs 0 (busy, done, pass, id_ok, ts_ok, timeout, id_value, ts_value, avm_read, avm_address); state IDLE. Reset mid-transaction drops avm_read at that edge; late readdatavalid after reset is ignored.
- start sampled at edge E0 -> busy and avm_read high in cycle after E0.
- Zero waitrequest, read latency 1: command cycle 1, valid cycle 2, command cycle 3, valid cycle 4, done in cycle 5 (five cycles after start edge). Each waitrequest cycle or extra latency cycle adds one.
- avm_address/avm_read change only on edges where the command is accepted (waitrequest=0) or at timeout/reset.
- done is high for exactly one cycle; busy falls in the same cycle done rises.

## Test plan
- Matching slave (0xACD51302/0x560CC9C4, waitrequest=0, latency 1): start -> done in cycle 5, pass=1, id_ok=1, ts_ok=1, id_value/ts_value equal inputs.
- Timestamp mismatch (word1 = 0x560CC9C5): -> id_ok=1, ts_ok=0, pass=0, timeout=0.
- Waitrequest held 3 cycles on each command, latency 2: avm_address/avm_read stable while stalled; done at cycle 13; pass=1.
- TIMEOUT_CYCLES=8, readdatavalid never asserted for word 0: timeout=1 and done 8 cycles after command start, pass=0, no read of address 1 issued.
- start pulsed again while busy and a stray readdatavalid in IDLE: no restart, no capture change; final results as for single run.
- Reset asserted in WAIT_TS: next cycle all outputs 0, state IDLE; subsequent start runs a clean check to pass=1.
